// File: rtl/bpf_forwarder_if.sv
// rtl/bpf_forwarder_if.sv - 64-bit packet stream between forwarder and egress
interface bpf_forwarder_if;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;

    modport master (
        output m_tdata, m_tkeep, m_tvalid, m_tlast,
        input  m_tready
    );

    modport slave (
        input  m_tdata, m_tkeep, m_tvalid, m_tlast,
        output m_tready
    );
endinterface

// File: rtl/bpf_forwarder.sv
// rtl/bpf_forwarder.sv - reads bpfvm packet buffers out of packet memory and streams them
module bpf_forwarder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ready_for_forwarder,
    input  logic [LEN_WIDTH-1:0]  packet_len,
    output logic [ADDR_WIDTH-1:0] forwarder_rd_addr,
    output logic                  forwarder_rd_en,
    input  logic [63:0]           forwarder_rd_data,
    output logic                  forwarder_done,
    output logic [31:0]           pkt_count,
    bpf_forwarder_if.master       m_axis
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_WIDTH:0] ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] MAX_BEAT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [1:0]          state_q, state_d;
    logic [ADDR_WIDTH:0] beats_q, beats_d;
    logic [ADDR_WIDTH:0] issued_q, issued_d;
    logic [ADDR_WIDTH:0] popped_q, popped_d;
    logic [7:0]          keep_last_q, keep_last_d;
    logic                inflight_q, inflight_d;
    logic [63:0]         fifo_mem_q [2];
    logic [63:0]         fifo_mem_d [2];
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          count_q, count_d;
    logic [31:0]         pkt_count_q, pkt_count_d;

    logic        head_valid;
    logic [63:0] head_data;
    logic        is_last;
    logic        pop;
    logic        pop_stored;
    logic        push;
    logic        rd_en;
    logic        len_part;
    logic        len_over;

    // Read data is presented straight from memory when the FIFO is empty, so
    // the first beat appears the cycle the read returns.
    always_comb begin
        head_valid = (count_q != 2'd0) || inflight_q;
        head_data  = (count_q != 2'd0) ? fifo_mem_q[rd_ptr_q] : forwarder_rd_data;
        is_last    = (popped_q == beats_q - ONE);
        pop        = head_valid && m_axis.m_tready;
        pop_stored = pop && (count_q != 2'd0);
        push       = inflight_q && !(pop && (count_q == 2'd0));
        rd_en      = (state_q == S_READ) &&
                     (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2);
        len_part   = |packet_len[2:0];
        len_over   = packet_len[ADDR_WIDTH+3] && (|packet_len[ADDR_WIDTH+2:0]);
    end

    assign m_axis.m_tvalid = head_valid;
    assign m_axis.m_tdata  = head_valid ? head_data : 64'd0;
    assign m_axis.m_tkeep  = head_valid ? (is_last ? keep_last_q : 8'hFF) : 8'h00;
    assign m_axis.m_tlast  = head_valid && is_last;

    assign forwarder_rd_en   = rd_en;
    assign forwarder_rd_addr = issued_q[ADDR_WIDTH-1:0];
    assign forwarder_done    = (state_q == S_DONE);
    assign pkt_count         = pkt_count_q;

    always_comb begin
        state_d     = state_q;
        beats_d     = beats_q;
        keep_last_d = keep_last_q;
        issued_d    = issued_q + (rd_en ? ONE : '0);
        popped_d    = popped_q + (pop ? ONE : '0);
        inflight_d  = rd_en;
        fifo_mem_d  = fifo_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + {1'b0, push} - {1'b0, pop_stored};
        pkt_count_d = pkt_count_q;

        if (push) begin
            fifo_mem_d[wr_ptr_q] = forwarder_rd_data;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop_stored) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case (state_q)
            S_IDLE: begin
                if (ready_for_forwarder) begin
                    issued_d = '0;
                    popped_d = '0;
                    // Oversized lengths fill the whole buffer with full beats.
                    if (len_over) begin
                        beats_d     = MAX_BEAT;
                        keep_last_d = 8'hFF;
                    end else begin
                        beats_d     = packet_len[ADDR_WIDTH+3:3] + {{ADDR_WIDTH{1'b0}}, len_part};
                        keep_last_d = len_part ? ~(8'hFF >> packet_len[2:0]) : 8'hFF;
                    end
                    state_d = (packet_len == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (rd_en && (issued_q == beats_q - ONE)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && is_last) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                pkt_count_d = pkt_count_q + 32'd1;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            beats_q       <= '0;
            keep_last_q   <= 8'h00;
            issued_q      <= '0;
            popped_q      <= '0;
            inflight_q    <= 1'b0;
            fifo_mem_q[0] <= 64'd0;
            fifo_mem_q[1] <= 64'd0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            pkt_count_q   <= 32'd0;
        end else begin
            state_q       <= state_d;
            beats_q       <= beats_d;
            keep_last_q   <= keep_last_d;
            issued_q      <= issued_d;
            popped_q      <= popped_d;
            inflight_q    <= inflight_d;
            fifo_mem_q[0] <= fifo_mem_d[0];
            fifo_mem_q[1] <= fifo_mem_d[1];
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            pkt_count_q   <= pkt_count_d;
        end
    end
endmodule

// File: tb/tb_bpf_forwarder.sv
// tb/tb_bpf_forwarder.sv - randomized self-checking bench for bpf_forwarder
module tb_bpf_forwarder;
    localparam int AW = 10;
    localparam int LW = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ready_for_forwarder = 1'b0;
    logic [LW-1:0] packet_len = '0;
    logic [AW-1:0] forwarder_rd_addr;
    logic          forwarder_rd_en;
    logic [63:0]   forwarder_rd_data = 64'd0;
    logic          forwarder_done;
    logic [31:0]   pkt_count;

    bpf_forwarder_if m_axis ();

    bpf_forwarder #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ready_for_forwarder (ready_for_forwarder),
        .packet_len          (packet_len),
        .forwarder_rd_addr   (forwarder_rd_addr),
        .forwarder_rd_en     (forwarder_rd_en),
        .forwarder_rd_data   (forwarder_rd_data),
        .forwarder_done      (forwarder_done),
        .pkt_count           (pkt_count),
        .m_axis              (m_axis)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [63:0] mem [1024];
    logic [72:0] exp_q [$];
    logic [72:0] act_beat;
    logic [72:0] exp_beat;
    logic [72:0] prev_beat;
    bit          prev_stall = 0;
    int          cur_beats = 0;
    int          rd_issued = 0;
    int          hs_count = 0;
    int          first_rd = -1;
    int          first_valid = -1;
    int          last_hs = -1;
    int          done_seen = 0;
    int          done_cyc = -1;
    int          max_addr = -1;
    logic [7:0]  last_keep = 8'h00;
    int          tr_mode = 0;
    int          exp_pkts = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (forwarder_rd_en) forwarder_rd_data <= mem[forwarder_rd_addr];
    end

    always @(posedge clk) begin
        #1;
        case (tr_mode)
            0:       m_axis.m_tready = 1'b1;
            1:       m_axis.m_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: m_axis.m_tready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            act_beat = {m_axis.m_tdata, m_axis.m_tkeep, m_axis.m_tlast};
            if (prev_stall) begin
                checks++;
                if (!m_axis.m_tvalid || act_beat != prev_beat) begin
                    errors++;
                    $display("FAIL stall_stable: got valid=%0b beat=%0h required valid=1 beat=%0h",
                             m_axis.m_tvalid, act_beat, prev_beat);
                end
            end
            if (forwarder_rd_en) begin
                checks++;
                if ((rd_issued - hs_count) >= 2 || int'(forwarder_rd_addr) != rd_issued ||
                    rd_issued >= cur_beats) begin
                    errors++;
                    $display("FAIL rd_port: got addr=%0d outstanding=%0d required addr=%0d outstanding<2 beats=%0d",
                             forwarder_rd_addr, rd_issued - hs_count, rd_issued, cur_beats);
                end
                if (first_rd < 0) first_rd = cyc;
                if (int'(forwarder_rd_addr) > max_addr) max_addr = int'(forwarder_rd_addr);
                rd_issued++;
            end
            if (m_axis.m_tvalid) begin
                if (first_valid < 0) first_valid = cyc;
                if (m_axis.m_tready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_beat: got beat=%0h required no beat", act_beat);
                    end else begin
                        exp_beat = exp_q.pop_front();
                        if (act_beat !== exp_beat) begin
                            errors++;
                            $display("FAIL beat%0d: got %0h required %0h", hs_count, act_beat, exp_beat);
                        end
                    end
                    hs_count++;
                    last_hs   = cyc;
                    last_keep = m_axis.m_tkeep;
                end
            end
            prev_stall = m_axis.m_tvalid && !m_axis.m_tready;
            prev_beat  = act_beat;
            if (forwarder_done) begin
                checks++;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL early_done: got %0d beats pending required 0", exp_q.size());
                end
                done_seen++;
                done_cyc = cyc;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, expv);
        end
    endtask

    function automatic int model_beats(input int len);
        if (len > 8 * 1024) return 1024;
        return (len + 7) / 8;
    endfunction

    task automatic build_model(input int len);
        int nb;
        int nbytes;
        logic [7:0] keep;
        nb = model_beats(len);
        exp_q.delete();
        for (int i = 0; i < nb; i++) begin
            nbytes = (len > 8 * 1024 || i < nb - 1) ? 8 : len - 8 * i;
            keep = 8'h00;
            for (int b = 0; b < nbytes; b++) keep[7-b] = 1'b1;
            exp_q.push_back({mem[i], keep, (i == nb - 1)});
        end
        cur_beats   = nb;
        rd_issued   = 0;
        hs_count    = 0;
        first_rd    = -1;
        first_valid = -1;
        last_hs     = -1;
        done_seen   = 0;
        max_addr    = -1;
    endtask

    task automatic run_pkt(input int len, input int mode, input bit immediate);
        int e0;
        int bound;
        int nb;
        nb = model_beats(len);
        build_model(len);
        tr_mode = mode;
        if (!immediate) begin
            @(posedge clk);
            #1;
        end
        ready_for_forwarder = 1'b1;
        packet_len = LW'(len);
        @(posedge clk);
        #1;
        e0 = cyc;
        ready_for_forwarder = 1'b0;
        bound = 0;
        while (done_seen == 0 && bound < 5000) begin
            @(posedge clk);
            #1;
            bound++;
        end
        chk("done_timeout", 64'(done_seen), 64'd1);
        exp_pkts++;
        chk("done_cycle", 64'(done_cyc), 64'((nb == 0) ? e0 : last_hs + 1));
        chk("done_width", 64'(forwarder_done), 64'd0);
        chk("beat_count", 64'(hs_count), 64'(nb));
        chk("beats_left", 64'(exp_q.size()), 64'd0);
        chk("pkt_count", 64'(pkt_count), 64'(exp_pkts));
        if (nb > 0) begin
            chk("first_rd_cycle", 64'(first_rd), 64'(e0));
            chk("first_valid_cycle", 64'(first_valid), 64'(e0 + 1));
        end else begin
            chk("zero_reads", 64'(rd_issued), 64'd0);
            chk("zero_valid", 64'(first_valid + 1), 64'd0);
        end
    endtask

    initial begin
        int bound;
        m_axis.m_tready = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
        mem[0] = 64'h70b31760_a09f782b;

        #1;
        chk("rst_valid", 64'(m_axis.m_tvalid), 64'd0);
        chk("rst_rd_en", 64'(forwarder_rd_en), 64'd0);
        chk("rst_done", 64'(forwarder_done), 64'd0);
        chk("rst_tlast", 64'(m_axis.m_tlast), 64'd0);
        chk("rst_tkeep", 64'(m_axis.m_tkeep), 64'd0);
        chk("rst_tdata", m_axis.m_tdata, 64'd0);
        chk("rst_rd_addr", 64'(forwarder_rd_addr), 64'd0);
        chk("rst_pkt_count", pkt_count, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        run_pkt(56, 0, 0);
        chk("p56_beats", 64'(hs_count), 64'd7);
        chk("p56_last_keep", 64'(last_keep), 64'hFF);
        chk("p56_max_addr", 64'(max_addr), 64'd6);
        chk("p56_pkt_count", pkt_count, 64'd1);

        run_pkt(44, 0, 0);
        chk("p44_beats", 64'(hs_count), 64'd6);
        chk("p44_last_keep", 64'(last_keep), 64'hF0);
        chk("p44_max_addr", 64'(max_addr), 64'd5);

        run_pkt(64, 1, 0);
        chk("p64_bp_beats", 64'(hs_count), 64'd8);

        run_pkt(0, 0, 0);
        chk("p0_pkt_count", pkt_count, 64'd4);

        run_pkt(16, 0, 0);
        run_pkt(8, 0, 1);
        chk("b2b_beats", 64'(hs_count), 64'd1);
        chk("b2b_pkt_count", pkt_count, 64'd6);

        build_model(56);
        tr_mode = 0;
        @(posedge clk);
        #1;
        ready_for_forwarder = 1'b1;
        packet_len = LW'(56);
        @(posedge clk);
        #1;
        ready_for_forwarder = 1'b0;
        bound = 0;
        while (hs_count < 3 && bound < 100) begin
            @(posedge clk);
            #1;
            bound++;
        end
        chk("mid_reach_beat2", 64'(hs_count >= 3), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(m_axis.m_tvalid), 64'd0);
        chk("mid_rst_rd_en", 64'(forwarder_rd_en), 64'd0);
        chk("mid_rst_done", 64'(forwarder_done), 64'd0);
        chk("mid_rst_tkeep", 64'(m_axis.m_tkeep), 64'd0);
        chk("mid_rst_pkt_count", pkt_count, 64'd0);
        exp_q.delete();
        exp_pkts = 0;
        done_seen = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_no_done", 64'(done_seen), 64'd0);
        run_pkt(8, 0, 0);
        chk("mid_after_pkt_count", pkt_count, 64'd1);

        run_pkt(9000, 0, 0);
        chk("clamp_beats", 64'(hs_count), 64'd1024);
        chk("clamp_last_keep", 64'(last_keep), 64'hFF);
        chk("clamp_max_addr", 64'(max_addr), 64'd1023);

        for (int k = 0; k < 12; k++) begin
            run_pkt(int'($urandom_range(0, 200)), int'($urandom_range(0, 2)), (k % 3) == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
